avalon_pio_gen: RTL and testbench

Parametrised Avalon-MM parallel I/O slave. It is the next generation of the single-bit output PIO used for USB HPI chip-select and similar strobes. It provides WIDTH bidirectional-capable bits with a per-bit direction register, synchronised inputs, edge capture, and a maskable level interrupt. It sits on the Nios II system interconnect alongside the existing PIO slaves.

---
 rtl/avalon_pio_pkg.sv | 19 +
 rtl/pio_edge_sync.sv | 52 +++++
 rtl/avalon_pio_gen.sv | 123 ++++++++++++
 tb/tb_avalon_pio_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pio_pkg.sv
// avalon_pio_pkg
// Shared constants for the avalon_pio_gen PIO slave: register addresses
// and edge-capture type encodings.
package avalon_pio_pkg;

    // Register map (3-bit word address)
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    // Edge capture selection
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_edge_sync.sv
// pio_edge_sync
// Synchronises asynchronous pin inputs and produces a one-clock edge pulse
// per bit, comparing the synchronised value against its previous sample.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   pins       raw asynchronous pin inputs (WIDTH)
//   in_sync    synchronised pin values (WIDTH)
//   edge_pulse per-bit edge of the selected type, valid for one clock (WIDTH)
module pio_edge_sync
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  in_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            in_prev <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            in_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign edge_pulse = in_sync & ~in_prev;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_pulse = ~in_sync & in_prev;
        end else begin : g_any
            assign edge_pulse = in_sync ^ in_prev;
        end
    endgenerate

endmodule

// File: rtl/avalon_pio_gen.sv
// avalon_pio_gen
// Avalon-MM parallel I/O slave: WIDTH bits with per-bit direction,
// synchronised inputs, edge capture and a maskable level interrupt.
//
// Optional build macro PIO_BIT_ACCESS_EN enables the OUTSET (4) and
// OUTCLR (5) registers; without it those addresses are reserved.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address        register select (3 bits)
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data (bits above WIDTH ignored)
//   readdata       combinational read data, upper bits zero
//   in_port        asynchronous pin inputs
//   out_port       output data register
//   oe             per-bit output enable (direction register)
//   irq            registered level interrupt
module avalon_pio_gen
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_pulse;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wdata     = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    pio_edge_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_edge_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .pins      (in_port),
        .in_sync   (in_sync),
        .edge_pulse(edge_pulse)
    );

    // Output data register, with optional atomic set/clear ports
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else if (wr) begin
            if (address == ADDR_DATA)
                data_out <= wdata;
`ifdef PIO_BIT_ACCESS_EN
            else if (address == ADDR_OUTSET)
                data_out <= data_out | wdata;
            else if (address == ADDR_OUTCLR)
                data_out <= data_out & ~wdata;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir      <= DIR_RESET;
            irq_mask <= '0;
        end else if (wr) begin
            if (address == ADDR_DIR)
                dir <= wdata;
            if (address == ADDR_MASK)
                irq_mask <= wdata;
        end
    end

    // Write-1-to-clear; a new edge in the same cycle overrides the clear
    assign edge_clr = (wr && address == ADDR_EDGE) ? wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            edge_cap <= (edge_cap & ~edge_clr) | edge_pulse;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
            ADDR_DIR:  readdata[WIDTH-1:0] = dir;
            ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edge_cap;
            default:   readdata = '0;
        endcase
    end

    assign out_port = data_out;
    assign oe       = dir;

endmodule

// File: tb/tb_avalon_pio_gen.sv
// tb_avalon_pio_gen
// Directed scenarios plus a randomized run against a register-level
// reference model of the PIO slave.
module tb_avalon_pio_gen;

    localparam int         W  = 8;
    localparam int         S  = 2;
    localparam int         ET = 0;
    localparam logic [7:0] RV = 8'hA5;
    localparam logic [7:0] DR = 8'h0F;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [31:0]  readdata;
    logic [W-1:0] in_port = '0;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic         irq;

    int errors = 0;
    int checks = 0;

`ifdef PIO_BIT_ACCESS_EN
    localparam bit BIT_ACCESS = 1'b1;
`else
    localparam bit BIT_ACCESS = 1'b0;
`endif

    avalon_pio_gen #(
        .WIDTH      (W),
        .RESET_VALUE(RV),
        .DIR_RESET  (DR),
        .EDGE_TYPE  (ET),
        .SYNC_STAGES(S)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .oe        (oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_port !== RV) begin errors++; $display("FAIL reset_out_port got=%h exp=%h", out_port, RV); end
        checks++; if (oe !== DR) begin errors++; $display("FAIL reset_oe got=%h exp=%h", oe, DR); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        address = 3'd1; #1;
        checks++; if (readdata !== 32'h0000000F) begin errors++; $display("FAIL reset_rd_dir got=%h exp=0000000f", readdata); end
        address = 3'd3; #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_rd_edge got=%h exp=0", readdata); end
        address = 3'd6; #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_rd_rsvd got=%h exp=0", readdata); end
    endtask

    task automatic test_data_read();
        wr(3'd1, 32'hFFFF_FFF0);
        wr(3'd0, 32'h1234_563C);
        @(negedge clk);
        in_port = 8'h9A;
        address = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (readdata !== 32'h3A) begin errors++; $display("FAIL data_read got=%h exp=0000003a", readdata); end
        checks++; if (out_port !== 8'h3C) begin errors++; $display("FAIL data_out_port got=%h exp=3c", out_port); end
        checks++; if (oe !== 8'hF0) begin errors++; $display("FAIL data_oe got=%h exp=f0", oe); end
    endtask

    task automatic test_edge_irq();
        @(negedge clk);
        in_port = '0;
        repeat (5) @(posedge clk);
        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h01);
        @(negedge clk);
        in_port[0] = 1'b1;
        address    = 3'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL edge_early got=%h exp=0", readdata); end
        @(posedge clk); @(negedge clk);
        checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL edge_set got=%h exp=1", readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq); end
        wr(3'd3, 32'h01);
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL edge_clear got=%h exp=0", readdata); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b exp=1", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got=%b exp=0", irq); end
    endtask

    task automatic test_clear_collision();
        @(negedge clk); in_port[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); in_port[0] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); in_port[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        address = 3'd3;
        checks++; if (readdata !== 32'h1 || irq !== 1'b1) begin errors++; $display("FAIL coll_setup got=%h/%b exp=1/1", readdata, irq); end
        in_port[0] = 1'b1;
        repeat (2) @(posedge clk);
        wr(3'd3, 32'h01);   // lands on the same edge the new pulse is captured
        checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL coll_edge got=%h exp=1", readdata); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_irq got=%b exp=1", irq); end
        @(posedge clk); #1;
        checks++; if (readdata !== 32'h1 || irq !== 1'b1) begin errors++; $display("FAIL coll_hold got=%h/%b exp=1/1", readdata, irq); end
        wr(3'd3, 32'hFF);
        repeat (2) @(posedge clk); #1;
        checks++; if (readdata !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL coll_cleanup got=%h/%b exp=0/0", readdata, irq); end
    endtask

    task automatic test_bit_access();
        logic [7:0] e1, e2;
        e1 = BIT_ACCESS ? 8'h3F : 8'h0F;
        e2 = BIT_ACCESS ? 8'h3A : 8'h0F;
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'h30);
        checks++; if (out_port !== e1) begin errors++; $display("FAIL outset got=%h exp=%h", out_port, e1); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rd_outset got=%h exp=0", readdata); end
        wr(3'd5, 32'h05);
        checks++; if (out_port !== e2) begin errors++; $display("FAIL outclr got=%h exp=%h", out_port, e2); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rd_outclr got=%h exp=0", readdata); end
        wr(3'd7, 32'hFF);
        checks++; if (out_port !== e2) begin errors++; $display("FAIL rsvd_write got=%h exp=%h", out_port, e2); end
    endtask

    task automatic test_async_reset();
        wr(3'd2, 32'hFF);
        @(negedge clk);
        address = 3'd0; writedata = 32'h55; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        writedata = 32'hC3;
        checks++; if (out_port !== 8'h55) begin errors++; $display("FAIL burst_pre got=%h exp=55", out_port); end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_port !== RV || oe !== DR || irq !== 1'b0) begin errors++; $display("FAIL async_reset got=%h/%h/%b exp=%h/%h/0", out_port, oe, irq, RV, DR); end
        checks++; if (readdata !== 32'h05) begin errors++; $display("FAIL async_rd got=%h exp=00000005", readdata); end
        address = 3'd3; #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL async_edge got=%h exp=0", readdata); end
        chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Reference model state
    logic [7:0] m_dout, m_dir, m_mask, m_ecap;
    logic       m_irq;
    logic [7:0] hist [0:S+1];   // hist[0] = most recently sampled pin value

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [7:0] synced;
        synced = hist[S-1];
        case (a)
            3'd0:    return {24'h0, (m_dir & m_dout) | (~m_dir & synced)};
            3'd1:    return {24'h0, m_dir};
            3'd2:    return {24'h0, m_mask};
            3'd3:    return {24'h0, m_ecap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_random();
        logic [7:0] cur, prv, edg, clr;
        logic       nirq;
        logic [31:0] exp_rd;
        do_reset();
        m_dout = RV; m_dir = DR; m_mask = '0; m_ecap = '0; m_irq = 1'b0;
        for (int i = 0; i <= S+1; i++) hist[i] = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            exp_rd = model_read(address);
            checks++; if (out_port !== m_dout) begin errors++; $display("FAIL rnd_out c=%0d got=%h exp=%h", c, out_port, m_dout); end
            checks++; if (oe !== m_dir) begin errors++; $display("FAIL rnd_oe c=%0d got=%h exp=%h", c, oe, m_dir); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, irq, m_irq); end
            checks++; if (readdata !== exp_rd) begin errors++; $display("FAIL rnd_rd c=%0d a=%0d got=%h exp=%h", c, address, readdata, exp_rd); end
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) in_port = 8'($urandom);
            @(posedge clk);
            cur = hist[S-1];
            prv = hist[S];
            case (ET)
                0:       edg = cur & ~prv;
                1:       edg = ~cur & prv;
                default: edg = cur ^ prv;
            endcase
            nirq = |(m_ecap & m_mask);
            clr  = '0;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_dout = writedata[7:0];
                    3'd1: m_dir  = writedata[7:0];
                    3'd2: m_mask = writedata[7:0];
                    3'd3: clr    = writedata[7:0];
                    3'd4: if (BIT_ACCESS) m_dout = m_dout | writedata[7:0];
                    3'd5: if (BIT_ACCESS) m_dout = m_dout & ~writedata[7:0];
                    default: ;
                endcase
            end
            m_ecap = (m_ecap & ~clr) | edg;
            m_irq  = nirq;
            for (int i = S+1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = in_port;
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_edge_irq();
        test_clear_collision();
        test_bit_access();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
